conv_mac_seq: RTL
=================

// Module: conv_mac_seq
// PURPOSE
//   Sequential 1-D convolution MAC directly downstream of the N-tap window shift register.
//   On start it snapshots the N-pixel window and multiplies it tap-by-tap (one MAC per cycle)
//   with a programmable signed kernel. It rounds, normalizes and clamps the sum to one output
//   pixel, then presents it on a valid/ready handshake to the next stage (writeback/2-D adder).
// PARAMETERS
//   N     = 11  number of taps; must match window depth of the upstream shift register
//   B     = 8   unsigned pixel width of window taps
//   CW    = 8   signed coefficient width
//   SHIFT = 6   normalization right-shift (kernel fixed point: 1.0 == 2**SHIFT)
//   OW    = 8   unsigned output pixel width
// PORTS
//   clk           in   1           rising-edge clock
//   rstn          in   1           synchronous active-low reset
//   coef_we       in   1           coefficient write strobe
//   coef_addr     in   $clog2(N)   coefficient index
//   coef_din      in   CW          signed coefficient value
//   start         in   1           begin one convolution on current win
//   win           in   B x [N-1:0] unpacked window taps; win[i] pairs with coef[i]
//   busy          out  1           high in any state other than IDLE
//   result        out  OW          clamped output pixel
//   result_valid  out  1           result holds valid data
//   result_ready  in   1           downstream accepts result
// BEHAVIOUR
//   - Reset (rstn low at a clk edge): state=IDLE; busy=0, result=0, result_valid=0.
//     Accumulator, tap index, window snapshot and all N coefficients are cleared to 0.
//     Reset applies in every state, including mid-MAC and HOLD.
//   - Accumulator width AW = B+CW+$clog2(N)+1, signed.
//     Each product is {1'b0,win_q[i]} * coef[i], sign-extended to AW.
//   - FSM:
//     IDLE: on start, capture win into win_q, clear acc, set idx=0, go to MAC.
//           Upstream may shift on the next cycle.
//     MAC: each edge does acc += win_q[idx]*coef[idx] and idx++.
//          After the idx==N-1 accumulate, go to NORM. MAC lasts exactly N cycles.
//     NORM: t = (acc + (SHIFT>0 ? 2**(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift).
//           Clamp t to [0, 2**OW-1] and register it into result.
//           Set result_valid=1 and go to HOLD.
//     HOLD: result and result_valid are held stable.
//           On an edge with result_ready=1: clear result_valid and go to IDLE.
//           result keeps its last value.
//   - Latency: the start-sampling edge is edge 0.
//     result_valid goes high after edge N+1 (edge 12 for N=11).
//     The minimum start-to-start interval is N+3 cycles when result_ready is held high.
//   - start is ignored while busy; it is not queued.
//     result_ready is ignored outside HOLD.
//   - Coefficient writes take effect only in IDLE; writes while busy are dropped.
//     Writes with coef_addr >= N are dropped.
//     A write and a start in the same IDLE cycle: the write lands, and MAC uses the new value.
// CONFIGURATION
//   CONV_MAC_ABS_EN defined:
//     NORM clamps |t| instead of t, giving gradient magnitude for edge kernels.
//     Negative sums produce positive pixels.
//   CONV_MAC_ABS_EN undefined:
//     negative t clamps to 0. No other behaviour differs.
// TESTING
//   1. Assert rstn=0 for 2 cycles in any state
//      -> busy=0, result_valid=0, result=0. A subsequent start with no coef writes yields result=0.
//   2. Identity: coef[5]=64, other coefs 0, win[5]=200, others random; start
//      -> result=200, valid after edge 12.
//   3. Box: all coef=1, all win=255
//      -> acc=2805, (2805+32)>>6 = 44 -> result=44.
//   4. Negative: coef[0]=-64, win[0]=100, other coefs 0
//      -> result=0; with CONV_MAC_ABS_EN -> result=100.
//   5. Saturation: all coef=127, all win=255 -> result=255.
//      All coef=-128 -> result=0, or 255 with ABS_EN.
//   6. Backpressure: result_ready=0 for 5 cycles, start pulsed during HOLD, coef write during MAC
//      -> result stable; start and write ignored; valid drops on the ready edge.
//      rstn=0 during MAC -> IDLE on the next edge.

Source files
------------

// File: rtl/conv_mac_seq.sv
// Sequential 1-D convolution MAC: snapshots an N-tap window on start, accumulates
// one tap product per cycle against a programmable signed kernel, then rounds,
// normalizes and clamps to one output pixel held on a valid/ready handshake.
// Optional feature macro: CONV_MAC_ABS_EN (clamp |t| instead of t).
module conv_mac_seq #(
    parameter int unsigned N     = 11,
    parameter int unsigned B     = 8,
    parameter int unsigned CW    = 8,
    parameter int unsigned SHIFT = 6,
    parameter int unsigned OW    = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    coef_we,
    input  logic [$clog2(N)-1:0]    coef_addr,
    input  logic signed [CW-1:0]    coef_din,
    input  logic                    start,
    input  logic [B-1:0]            win [N-1:0],
    output logic                    busy,
    output logic [OW-1:0]           result,
    output logic                    result_valid,
    input  logic                    result_ready
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = B + CW + 1;
    localparam int unsigned AW = B + CW + IW + 1;
    localparam logic signed [AW-1:0] RND  = (SHIFT > 0) ? AW'(1 << (SHIFT - 1)) : '0;
    localparam logic signed [AW-1:0] OMAX = AW'((64'(1) << OW) - 64'(1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_NORM = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic signed [AW-1:0]   acc;
    logic [IW-1:0]          idx;
    logic [B-1:0]           win_q  [N-1:0];
    logic signed [CW-1:0]   coef_q [N-1:0];

    logic signed [PW-1:0]   prod_c;
    logic signed [AW-1:0]   acc_add_c;
    logic signed [AW-1:0]   sum_c;
    logic signed [AW-1:0]   t_c;
    logic signed [AW-1:0]   mag_c;
    logic [OW-1:0]          clamp_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_MAC;
            S_MAC:   if (idx == IW'(N - 1)) state_nxt = S_NORM;
            S_NORM:  state_nxt = S_HOLD;
            S_HOLD:  if (result_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Tap product, accumulate, round/shift and clamp arithmetic
    always_comb begin
        prod_c    = PW'($signed({1'b0, win_q[idx]})) * PW'(coef_q[idx]);
        acc_add_c = acc + AW'(prod_c);
        sum_c     = acc + RND;
        t_c       = sum_c >>> SHIFT;
`ifdef CONV_MAC_ABS_EN
        mag_c     = t_c[AW-1] ? -t_c : t_c;
`else
        mag_c     = t_c;
`endif
        if (mag_c[AW-1]) begin
            clamp_c = '0;
        end else if (mag_c > OMAX) begin
            clamp_c = '1;
        end else begin
            clamp_c = mag_c[OW-1:0];
        end
    end

    // Datapath registers: coefficients, window snapshot, accumulator, result
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc          <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                win_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            busy <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (coef_we && (32'(coef_addr) < N)) begin
                        coef_q[coef_addr] <= coef_din;
                    end
                    if (start) begin
                        win_q <= win;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc_add_c;
                    idx <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
                end
                S_NORM: begin
                    result       <= clamp_c;
                    result_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (result_ready) result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
